emmc_link_scheduler: RTL and testbench
======================================

// Module: emmc_link_scheduler
// PURPOSE
//  Frame scheduler for the eMMC chip-to-chip serdes TX path. Arbitrates between the
//  eMMC command channel (48-bit CMD tokens) and the data channel (bytes from the
//  AXI/SD data FIFO), wraps each grant in a framed packet and drives the byte-wide
//  parallel TX interface feeding the serdes serializer. Runs in the serdes divided-clock domain.
// PARAMETERS
//  MAX_BURST  32  max DAT payload bytes per frame, legal 1..64
//  LEVEL_W    10  width of the dat_level FIFO fill count
// PORTS
//  aclk        in   1        serdes divided clock; all logic on rising edge
//  aresetn     in   1        asynchronous, active-low reset
//  link_up     in   1        link trained; low = no new frame starts
//  cmd_req     in   1        CMD token pending; held until cmd_ack
//  cmd_word    in   48       CMD token; stable while cmd_req high
//  cmd_ack     out  1        one-cycle pulse, cycle after cmd_word captured
//  dat_level   in   LEVEL_W  bytes available in data FIFO (first-word-fall-through)
//  dat_data    in   8        FIFO head byte, valid when dat_level != 0
//  dat_ready   out  1        FIFO pop; one pulse per payload byte taken
//  tx_data     out  8        frame byte to serializer
//  tx_valid    out  1        tx_data valid
//  tx_ready    in   1        serializer accepts byte when tx_valid && tx_ready
//  busy        out  1        frame in progress (state != IDLE)
//  last_grant  out  1        0 = last frame was CMD, 1 = DAT
// BEHAVIOUR
//  Reset: tx_data=0, tx_valid=0, cmd_ack=0, dat_ready=0, busy=0, last_grant=1, state=IDLE.
//  Frame = header {type[1:0], len_m1[5:0]} + payload; type 2'b01 CMD, 2'b10 DAT.
//   CMD: len_m1=5, 6 bytes, cmd_word[47:40] first. DAT: len_m1=L-1, L=min(dat_level,MAX_BURST).
//  Output register: tx_data/tx_valid registered; next byte loads when !tx_valid || tx_ready;
//   tx_data held stable while tx_valid && !tx_ready. Back-to-back frames, no gap bytes.
//  States: IDLE -> HDR -> CMD_PAY | DAT_PAY -> (CRC) -> IDLE.
//   IDLE: start only if link_up and (cmd_req or dat_level!=0) and output reg loadable.
//   Arbitration round-robin at frame boundaries: both pending -> grant opposite of
//   last_grant; single requester always wins. Header loaded at grant edge, so first
//   header byte is on tx_valid 1 cycle after grant; last_grant updated at grant.
//   CMD grant: cmd_word captured at grant edge, cmd_ack pulses next cycle.
//   DAT grant: L snapshotted at grant; dat_level only grows meanwhile, so pops never underflow.
//   DAT_PAY: dat_ready asserted exactly in the cycles a payload byte loads; exactly L pops.
//   Payload counter 6 bits, counts len_m1 down to 0; last byte -> CRC or IDLE.
//  link_up falling mid-frame: current frame completes; no new grant until link_up high.
//  cmd_req deasserted before grant: no frame. cmd_req high again after ack: new token.
//  Async reset mid-frame: frame truncated, outputs to reset values immediately; the
//   receiver resyncs via link retraining (link_up low).
// CONFIGURATION
//  EMMC_LINK_CRC_EN defined: CRC state appends 1 byte CRC-8 (poly 0x07, init 0x00,
//   MSB-first) over header+payload; frame = payload+2 bytes.
//  Undefined: no CRC state/logic; frame = payload+1 bytes; DAT_PAY/CMD_PAY -> IDLE.
// TESTING
//  1 CMD only: cmd_word=48'h40_0000_0000_95, tx_ready=1 -> bytes 45,40,00,00,00,00,95;
//    cmd_ack one pulse; tx_valid contiguous 7 cycles (8 with CRC).
//  2 DAT only: dat_level=3, FIFO AA,BB,CC -> 82,AA,BB,CC; exactly 3 dat_ready pulses.
//  3 Burst cap: dat_level=100, MAX_BURST=32 -> header 9F + 32 bytes, then header 9F
//    + 32 bytes, then A3 + 36 bytes? no: third frame A3 is len 36>32 -> 9F,32 bytes,
//    then 83 + 4 bytes (100=32+32+32+4); total 100 pops.
//  4 Contention: cmd_req and dat_level=4 held, last_grant=1 after reset -> CMD frame,
//    then DAT frame (83..), then next CMD if re-requested: strict alternation.
//  5 Backpressure: tx_ready toggles 1/0 each cycle during DAT frame -> tx_data stable
//    while stalled, no dropped/duplicated bytes, pops match bytes accepted.
//  6 Reset/link: aresetn low mid-CMD payload -> all outputs 0 within same cycle;
//    link_up low mid-DAT frame -> frame completes, no further header until link_up=1.

Source files
------------

// File: rtl/emmc_link_scheduler.sv
// ---------------------------------------------------------------------------
// emmc_link_scheduler
//
// Frame scheduler for the eMMC chip-to-chip serdes TX path. Arbitrates between
// the CMD channel (48-bit tokens) and the DAT channel (bytes from a
// first-word-fall-through FIFO). Each grant is wrapped in a framed packet:
//   header {type[1:0], len_m1[5:0]} + payload [+ CRC-8]
//   type 2'b01 = CMD (always 6 payload bytes, MSB first)
//   type 2'b10 = DAT (L = min(dat_level, MAX_BURST) bytes)
// Frames are driven byte-wide into the serializer through a registered
// valid/ready output stage.
//
// Optional feature macro: EMMC_LINK_CRC_EN
//   defined   -> a CRC-8 byte (poly 0x07, init 0x00, MSB first) over header
//                and payload is appended to every frame.
//   undefined -> no CRC state or logic; frames end after the payload.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   link_up              low blocks new frames (a running frame completes)
//   cmd_req / cmd_word   CMD token handshake; cmd_ack pulses after capture
//   dat_level / dat_data FIFO fill count and head byte
//   dat_ready            FIFO pop, one per payload byte loaded
//   tx_data / tx_valid   registered output byte to the serializer
//   tx_ready             serializer accept
//   busy                 a frame is in progress
//   last_grant           0 = last frame was CMD, 1 = DAT
// ---------------------------------------------------------------------------
module emmc_link_scheduler #(
    parameter int MAX_BURST = 32,
    parameter int LEVEL_W   = 10
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               link_up,
    input  logic               cmd_req,
    input  logic [47:0]        cmd_word,
    output logic               cmd_ack,
    input  logic [LEVEL_W-1:0] dat_level,
    input  logic [7:0]         dat_data,
    output logic               dat_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               last_grant
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CMD_PAY,
        ST_DAT_PAY
`ifdef EMMC_LINK_CRC_EN
        , ST_CRC
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        cmd_ack_q, cmd_ack_d;
    logic        last_grant_q, last_grant_d;
    logic [47:0] cmd_word_q, cmd_word_d;
    logic [5:0]  cnt_q, cnt_d;
`ifdef EMMC_LINK_CRC_EN
    logic [7:0]  crc_q, crc_d;

    // Byte-at-a-time CRC-8, polynomial x^8+x^2+x+1, MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    logic       load_ok;
    logic       cmd_pend;
    logic       dat_pend;
    logic       grant_dat;
    logic       pay_is_dat;
    logic [6:0] burst_len;
    logic [5:0] burst_m1;
    logic [7:0] hdr_byte;
    logic [7:0] cmd_byte;
    logic [7:0] pay_byte;

    // The output slot can take a new byte when empty or being drained this cycle.
    assign load_ok  = !tx_valid_q || tx_ready;
    assign cmd_pend = cmd_req;
    assign dat_pend = (dat_level != '0);

    // Round-robin: with both pending, grant the channel that did not go last.
    assign grant_dat = dat_pend && (!cmd_pend || !last_grant_q);

    assign burst_len = (dat_level >= LEVEL_W'(MAX_BURST)) ? 7'(MAX_BURST) : 7'(dat_level);
    assign burst_m1  = 6'(burst_len - 7'd1);
    assign hdr_byte  = grant_dat ? {2'b10, burst_m1} : {2'b01, 6'd5};

    // The counter runs len_m1..0, so for CMD it also selects byte 5 (MSB) first.
    assign cmd_byte   = 8'(cmd_word_q >> {cnt_q, 3'b000});
    // In HDR the frame type is the grant just recorded in last_grant_q.
    assign pay_is_dat = (state_q == ST_DAT_PAY) || ((state_q == ST_HDR) && last_grant_q);
    assign pay_byte   = pay_is_dat ? dat_data : cmd_byte;

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        cmd_ack_d    = 1'b0;
        last_grant_d = last_grant_q;
        cmd_word_d   = cmd_word_q;
        cnt_d        = cnt_q;
        dat_ready    = 1'b0;
`ifdef EMMC_LINK_CRC_EN
        crc_d        = crc_q;
`endif
        // A drained slot goes empty unless a byte is loaded below.
        if (load_ok) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (link_up && (cmd_pend || dat_pend) && load_ok) begin
                    tx_data_d    = hdr_byte;
                    tx_valid_d   = 1'b1;
                    last_grant_d = grant_dat;
                    state_d      = ST_HDR;
                    if (grant_dat) begin
                        cnt_d = burst_m1;
                    end else begin
                        cnt_d      = 6'd5;
                        cmd_word_d = cmd_word;
                        cmd_ack_d  = 1'b1;
                    end
`ifdef EMMC_LINK_CRC_EN
                    crc_d = crc8_byte(8'h00, hdr_byte);
`endif
                end
            end
            ST_HDR, ST_CMD_PAY, ST_DAT_PAY: begin
                if (load_ok) begin
                    tx_data_d  = pay_byte;
                    tx_valid_d = 1'b1;
                    dat_ready  = pay_is_dat;
`ifdef EMMC_LINK_CRC_EN
                    crc_d = crc8_byte(crc_q, pay_byte);
`endif
                    if (cnt_q == 6'd0) begin
`ifdef EMMC_LINK_CRC_EN
                        state_d = ST_CRC;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        cnt_d   = cnt_q - 6'd1;
                        state_d = pay_is_dat ? ST_DAT_PAY : ST_CMD_PAY;
                    end
                end
            end
`ifdef EMMC_LINK_CRC_EN
            ST_CRC: begin
                if (load_ok) begin
                    tx_data_d  = crc_q;
                    tx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            cmd_ack_q    <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_word_q   <= 48'h0;
            cnt_q        <= 6'd0;
`ifdef EMMC_LINK_CRC_EN
            crc_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            cmd_ack_q    <= cmd_ack_d;
            last_grant_q <= last_grant_d;
            cmd_word_q   <= cmd_word_d;
            cnt_q        <= cnt_d;
`ifdef EMMC_LINK_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign cmd_ack    = cmd_ack_q;
    assign last_grant = last_grant_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_emmc_link_scheduler.sv
// ---------------------------------------------------------------------------
// tb_emmc_link_scheduler
//
// Drives emmc_link_scheduler with CMD tokens and a FIFO model, collects every
// byte accepted by the serializer side and compares the stream against frames
// built from the framing/arbitration rules (round-robin, burst cap, CRC when
// EMMC_LINK_CRC_EN is defined). Also covers reset values, backpressure
// stability, asynchronous reset mid-frame and link_up gating.
// ---------------------------------------------------------------------------
module tb_emmc_link_scheduler;

    localparam int MAX_BURST = 32;
    localparam int LEVEL_W   = 10;
`ifdef EMMC_LINK_CRC_EN
    localparam int CRC_BYTES = 1;
`else
    localparam int CRC_BYTES = 0;
`endif

    logic               aclk = 1'b0;
    logic               aresetn;
    logic               link_up;
    logic               cmd_req;
    logic [47:0]        cmd_word;
    logic               cmd_ack;
    logic [LEVEL_W-1:0] dat_level;
    logic [7:0]         dat_data;
    logic               dat_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               last_grant;

    always #5 aclk = ~aclk;

    emmc_link_scheduler #(.MAX_BURST(MAX_BURST), .LEVEL_W(LEVEL_W)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .link_up    (link_up),
        .cmd_req    (cmd_req),
        .cmd_word   (cmd_word),
        .cmd_ack    (cmd_ack),
        .dat_level  (dat_level),
        .dat_data   (dat_data),
        .dat_ready  (dat_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .last_grant (last_grant)
    );

    // First-word-fall-through FIFO model: pushed by the stimulus, popped on dat_ready.
    logic [7:0] fifo_mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign dat_level = LEVEL_W'(wr_ptr - rd_ptr);
    assign dat_data  = fifo_mem[rd_ptr % 4096];
    always @(posedge aclk) if (dat_ready) rd_ptr <= rd_ptr + 1;

    // Serializer-side monitor, sampled mid-cycle.
    logic [7:0] rx_q[$];
    bit         vhist[$];
    int         pop_cnt = 0;
    int         ack_cnt = 0;
    int         stall_err = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge aclk) begin
        if (aresetn) begin
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (dat_ready) pop_cnt++;
            if (cmd_ack) ack_cnt++;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            vhist.push_back(tx_valid);
        end else begin
            prev_stall = 1'b0;
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [47:0] tok_q[$];
    logic [7:0]  byte_q[$];
    logic [7:0]  exp_q[$];
    bit          model_last = 1'b1;

`ifdef EMMC_LINK_CRC_EN
    // Bit-serial long division of the frame bit stream by 0x107.
    function automatic logic [7:0] ref_crc(input logic [7:0] frame[$]);
        logic [7:0] r = 8'h00;
        foreach (frame[i]) begin
            for (int b = 7; b >= 0; b--) begin
                bit fb = r[7] ^ frame[i][b];
                r = {r[6:0], 1'b0};
                if (fb) r = r ^ 8'h07;
            end
        end
        return r;
    endfunction
`endif

    // Assumes both channels stay pending while they have work: alternation
    // whenever both have something, otherwise the lone requester.
    task automatic build_expected();
        int ti = 0;
        int bi = 0;
        logic [7:0] frame[$];
        bit take_dat;
        int len;
        exp_q.delete();
        while (ti < tok_q.size() || bi < byte_q.size()) begin
            frame.delete();
            if (ti < tok_q.size() && bi < byte_q.size()) take_dat = !model_last;
            else take_dat = (bi < byte_q.size());
            if (take_dat) begin
                len = byte_q.size() - bi;
                if (len > MAX_BURST) len = MAX_BURST;
                frame.push_back(8'h80 + 8'(len - 1));
                for (int k = 0; k < len; k++) frame.push_back(byte_q[bi + k]);
                bi += len;
            end else begin
                frame.push_back(8'h45);
                for (int k = 5; k >= 0; k--) frame.push_back(tok_q[ti][8*k +: 8]);
                ti++;
            end
`ifdef EMMC_LINK_CRC_EN
            frame.push_back(ref_crc(frame));
`endif
            foreach (frame[k]) exp_q.push_back(frame[k]);
            model_last = take_dat;
        end
    endtask

    task automatic push_fifo();
        foreach (byte_q[k]) begin
            fifo_mem[wr_ptr % 4096] = byte_q[k];
            wr_ptr++;
        end
    endtask

    task automatic compare_stream(input string tag, input int rx_base);
        int n;
        check({tag, " rx_len"}, 64'(rx_q.size() - rx_base), 64'(exp_q.size()));
        n = rx_q.size() - rx_base;
        if (n > exp_q.size()) n = exp_q.size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s byte%0d", tag, k), 64'(rx_q[rx_base + k]), 64'(exp_q[k]));
    endtask

    // ready_mode: 0 = always ready, 1 = toggle each cycle, 2 = random (75% ready)
    task automatic run_traffic(input string tag, input int ready_mode);
        int rx_base = rx_q.size();
        int pop_base = pop_cnt;
        int ack_base = ack_cnt;
        int err_base = stall_err;
        int v_base = vhist.size();
        int ntok = tok_q.size();
        int nbytes = byte_q.size();
        int ti = 0;
        int cyc = 0;
        int run = 0;
        int best = 0;
        bit done = 1'b0;
        build_expected();
        push_fifo();
        if (ntok > 0) begin
            cmd_word = tok_q[0];
            cmd_req  = 1'b1;
        end
        tx_ready = 1'b1;
        while (!done && cyc < 3000) begin
            @(posedge aclk); #1;
            cyc++;
            if (cmd_ack) begin
                ti++;
                if (ti < ntok) cmd_word = tok_q[ti];
                else cmd_req = 1'b0;
            end
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = ($urandom_range(0, 3) != 0);
            endcase
            done = (ti >= ntok) && (pop_cnt - pop_base == nbytes) && !busy && !tx_valid;
        end
        cmd_req  = 1'b0;
        tx_ready = 1'b1;
        check({tag, " completes"}, 64'(done), 64'd1);
        compare_stream(tag, rx_base);
        check({tag, " pops"}, 64'(pop_cnt - pop_base), 64'(nbytes));
        check({tag, " acks"}, 64'(ack_cnt - ack_base), 64'(ntok));
        check({tag, " stall_stable"}, 64'(stall_err - err_base), 64'd0);
        check({tag, " last_grant"}, 64'(last_grant), 64'(model_last));
        if (ready_mode == 0) begin
            for (int k = v_base; k < vhist.size(); k++) begin
                if (vhist[k]) begin
                    run++;
                    if (run > best) best = run;
                end else run = 0;
            end
            check({tag, " contiguous"}, 64'(best), 64'(exp_q.size()));
        end
    endtask

    initial begin
        int rx_base;
        int pop_base;
        int cyc;

        aresetn  = 1'b0;
        link_up  = 1'b0;
        cmd_req  = 1'b0;
        cmd_word = 48'h0;
        tx_ready = 1'b0;
        repeat (2) @(negedge aclk);
        check("reset tx_data", 64'(tx_data), 64'h00);
        check("reset tx_valid", 64'(tx_valid), 64'd0);
        check("reset cmd_ack", 64'(cmd_ack), 64'd0);
        check("reset dat_ready", 64'(dat_ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset last_grant", 64'(last_grant), 64'd1);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        link_up = 1'b1;

        // CMD only
        tok_q = '{48'h40_0000_0000_95};
        byte_q.delete();
        rx_base = rx_q.size();
        run_traffic("cmd_only", 0);
        check("cmd_only hdr", 64'(rx_q[rx_base]), 64'h45);
        check("cmd_only tail", 64'(rx_q[rx_base + 6]), 64'h95);
        $display("[TB] cmd_only done");

        // DAT only
        tok_q.delete();
        byte_q = '{8'hAA, 8'hBB, 8'hCC};
        rx_base = rx_q.size();
        run_traffic("dat_only", 0);
        check("dat_only hdr", 64'(rx_q[rx_base]), 64'h82);
        $display("[TB] dat_only done");

        // Burst cap: 100 bytes -> 32+32+32+4
        byte_q.delete();
        for (int k = 0; k < 100; k++) byte_q.push_back(8'($urandom));
        run_traffic("burst_cap", 0);
        $display("[TB] burst_cap done");

        // Contention: both pending, strict alternation starting with CMD
        tok_q = '{48'($urandom) << 16 | 48'h1234, 48'hA5A5_0F0F_3C3C};
        byte_q.delete();
        for (int k = 0; k < 8; k++) byte_q.push_back(8'($urandom));
        run_traffic("contention", 0);
        $display("[TB] contention done");

        // Backpressure toggling
        tok_q.delete();
        byte_q.delete();
        for (int k = 0; k < 20; k++) byte_q.push_back(8'($urandom));
        run_traffic("backpressure", 1);
        $display("[TB] backpressure done");

        // Randomized mixes
        for (int it = 0; it < 4; it++) begin
            tok_q.delete();
            byte_q.delete();
            for (int k = 0; k < $urandom_range(0, 3); k++) tok_q.push_back({16'($urandom), 32'($urandom)});
            for (int k = 0; k < $urandom_range(1, 80); k++) byte_q.push_back(8'($urandom));
            run_traffic($sformatf("random%0d", it), 2);
            $display("[TB] random%0d done: %0d tokens, %0d bytes", it, tok_q.size(), byte_q.size());
        end

        // Asynchronous reset in the middle of a CMD payload
        cmd_word = 48'h1122_3344_5566;
        cmd_req  = 1'b1;
        tx_ready = 1'b1;
        cyc = 0;
        while (!busy && cyc < 20) begin
            @(posedge aclk); #1;
            cyc++;
        end
        check("rst_mid grant", 64'(busy), 64'd1);
        cmd_req = 1'b0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        check("rst_mid pre last_grant", 64'(last_grant), 64'd0);
        #2 aresetn = 1'b0;
        #1;
        check("rst_mid tx_valid", 64'(tx_valid), 64'd0);
        check("rst_mid tx_data", 64'(tx_data), 64'h00);
        check("rst_mid busy", 64'(busy), 64'd0);
        check("rst_mid cmd_ack", 64'(cmd_ack), 64'd0);
        check("rst_mid dat_ready", 64'(dat_ready), 64'd0);
        check("rst_mid last_grant", 64'(last_grant), 64'd1);
        @(posedge aclk); #1;
        aresetn    = 1'b1;
        model_last = 1'b1;
        $display("[TB] reset mid-frame done");

        // link_up falls mid DAT frame: the frame completes, nothing further starts
        tok_q.delete();
        byte_q.delete();
        for (int k = 0; k < 40; k++) byte_q.push_back(8'($urandom));
        rx_base  = rx_q.size();
        pop_base = pop_cnt;
        build_expected();
        push_fifo();
        cyc = 0;
        while (!busy && cyc < 20) begin
            @(posedge aclk); #1;
            cyc++;
        end
        check("link grant", 64'(busy), 64'd1);
        link_up = 1'b0;
        repeat (60) @(posedge aclk);
        #1;
        check("link held pops", 64'(pop_cnt - pop_base), 64'd32);
        check("link held rx_len", 64'(rx_q.size() - rx_base), 64'(33 + CRC_BYTES));
        check("link held busy", 64'(busy), 64'd0);
        check("link held tx_valid", 64'(tx_valid), 64'd0);
        link_up = 1'b1;
        cyc = 0;
        while (!((pop_cnt - pop_base == 40) && !busy && !tx_valid) && cyc < 200) begin
            @(posedge aclk); #1;
            cyc++;
        end
        check("link resume completes", 64'(cyc < 200), 64'd1);
        compare_stream("link", rx_base);
        $display("[TB] link_up gating done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
